// File: rtl/gf2_poly_affine_31.sv
// Carry-less affine map r(x) = (x^4 + 1)·p(x) + 1 over GF(2), 31-bit operand to 35-bit result.
// One-cycle registered pipeline with no backpressure; outputs come straight from flops.
module gf2_poly_affine_31 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [30:0] in_poly,
  output logic        out_valid,
  output logic [34:0] out_poly
);

  logic [34:0] result_s;
  logic        out_valid_r;
  logic [34:0] out_poly_r;

  // Coefficient-wise form of the product plus constant; the high nibble carries p[30:27] unreduced.
  function automatic logic [34:0] affine_eval(input logic [30:0] p);
    logic [34:0] r;
    r    = 35'd0;
    r[0] = p[0] ^ 1'b1;
    for (int i = 1; i < 4; i++) begin
      r[i] = p[i];
    end
    for (int i = 4; i < 31; i++) begin
      r[i] = p[i] ^ p[i-4];
    end
    for (int i = 31; i < 35; i++) begin
      r[i] = p[i-4];
    end
    return r;
  endfunction

  // Evaluate the affine map on the incoming operand.
  always_comb begin
    result_s = 35'd0;
    if (in_valid) begin
      result_s = affine_eval(in_poly);
    end else begin
      result_s = out_poly_r;
    end
  end

  // Output register: reset clears to zero, idle cycles hold the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_poly_r  <= 35'd0;
    end else if (in_valid) begin
      out_valid_r <= 1'b1;
      out_poly_r  <= result_s;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid = out_valid_r;
  assign out_poly  = out_poly_r;

endmodule

// File: tb/tb_gf2_poly_affine_31.sv
// Self-checking bench for gf2_poly_affine_31: directed vector table, stream/reset sequences,
// and a random sweep, all scored through an expected-result queue.
module tb_gf2_poly_affine_31;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [30:0] in_poly;
  logic        out_valid;
  logic [34:0] out_poly;

  gf2_poly_affine_31 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_poly  (in_poly),
    .out_valid(out_valid),
    .out_poly (out_poly)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [30:0] p;
    logic [34:0] exp;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [34:0] exp_q[$];
  logic [34:0] last_out = 35'd0;

  function automatic logic [34:0] ref_model(input logic [30:0] p);
    logic [34:0] pe;
    pe = {4'd0, p};
    return (pe << 4) ^ pe ^ 35'd1;
  endfunction

  task automatic check(input string name, input logic [34:0] act, input logic [34:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%09h, expected 0x%09h", name, act, req);
    end
  endtask

  // One clock of stimulus; expected result is queued at drive time and checked #1 after the edge.
  task automatic drive(input logic v, input logic [30:0] p, input string name);
    logic [34:0] e;
    in_valid = v;
    in_poly  = p;
    if (v) exp_q.push_back(ref_model(p));
    @(posedge clk);
    #1;
    if (v) begin
      if (exp_q.size() == 0) begin
        check({name, "_queue_empty"}, 35'd1, 35'd0);
      end else begin
        e = exp_q.pop_front();
        check({name, "_valid"}, {34'd0, out_valid}, 35'd1);
        check({name, "_poly"}, out_poly, e);
        last_out = e;
      end
    end else begin
      check({name, "_valid_low"}, {34'd0, out_valid}, 35'd0);
      check({name, "_hold"}, out_poly, last_out);
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{p: 31'h1C80317F, exp: 35'h1D483268E};
    vecs[1] = '{p: 31'h00000000, exp: 35'h000000001};
    vecs[2] = '{p: 31'h00000001, exp: 35'h000000010};
    vecs[3] = '{p: 31'h7FFFFFFF, exp: 35'h78000000E};
    vecs[4] = '{p: 31'h40000000, exp: 35'h440000001};
    vecs[5] = '{p: 31'h00000010, exp: 35'h000000111};

    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_poly  = 31'h12345678;
    #1;
    check("reset_async_valid", {34'd0, out_valid}, 35'd0);
    check("reset_async_poly", out_poly, 35'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold_valid", {34'd0, out_valid}, 35'd0);
    check("reset_hold_poly", out_poly, 35'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    drive(1'b0, 31'h0, "post_reset_idle");

    // Directed table: constant vectors checked directly, not through the model.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_poly  = vecs[i].p;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), {34'd0, out_valid}, 35'd1);
      check($sformatf("vec%0d_poly", i), out_poly, vecs[i].exp);
      last_out = vecs[i].exp;
    end
    drive(1'b0, 31'h7FFFFFFF, "table_idle");

    // Back-to-back stream then idle with a don't-care operand.
    drive(1'b1, 31'h00000003, "stream0");
    drive(1'b1, 31'h2AAAAAAA, "stream1");
    drive(1'b1, 31'h55555555, "stream2");
    drive(1'b1, 31'h0F0F0F0F, "stream3");
    drive(1'b0, 31'h7FFFFFFF, "stream_end0");
    drive(1'b0, 31'h00000000, "stream_end1");

    // Mid-stream reset between edges discards the pending result.
    drive(1'b1, 31'h1C80317F, "pre_reset");
    in_valid = 1'b1;
    in_poly  = 31'h00000001;
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_valid", {34'd0, out_valid}, 35'd0);
    check("midreset_poly", out_poly, 35'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    check("midreset_edge_valid", {34'd0, out_valid}, 35'd0);
    check("midreset_edge_poly", out_poly, 35'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    last_out = 35'd0;
    drive(1'b0, 31'h00000005, "after_release_idle");
    drive(1'b1, 31'h00000001, "after_release_first");

    // Random sweep with occasional idle cycles.
    for (int i = 0; i < 10000; i++) begin
      logic        v;
      logic [30:0] p;
      v = ($urandom_range(0, 7) != 0);
      p = 31'($urandom());
      if (v) drive(1'b1, p, "rand");
      else   drive(1'b0, p, "rand_idle");
    end

    check("queue_drained", 35'(exp_q.size()), 35'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gf2_poly_affine_31.md
GF2_POLY_AFFINE_31 -- requirements
Module: gf2_poly_affine_31

Interface
REQ-001 The block SHALL have no parameters; a(x) = x^4 + 1, c(x) = 1, input width 31 and output width 35 are fixed constants.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  high when in_poly carries an operand to process this cycle.
REQ-005 in_poly  input  31  operand p(x); bit i is the coefficient of x^i.
REQ-006 out_valid  output  1  high for exactly the cycle(s) in which out_poly holds a fresh result.
REQ-007 out_poly  output  35  result a(x)p(x) + c(x) over GF(2); bit i is the coefficient of x^i.
REQ-008 Every output SHALL be driven directly from a flip-flop, with no combinational path from any input to any output.

Function
REQ-009 The result r(x) = (x^4 + 1)·p(x) + 1 SHALL be computed over GF(2), i.e. carry-less: r = (p << 4) XOR p XOR 1, zero-extended to 35 bits.
REQ-010 The result bits SHALL be defined as follows:
- r[0] = p[0] XOR 1.
- r[3:1] = p[3:1].
- r[i] = p[i] XOR p[i-4] for i = 4..30.
- r[34:31] = p[30:27].
REQ-011 No modular reduction SHALL be applied; the full 35-bit product-plus-constant SHALL be output, with no truncation or overflow.
REQ-012 Latency SHALL be exactly 1 cycle: when in_valid = 1 at rising edge N, out_poly = r(in_poly) and out_valid = 1 after edge N.
REQ-013 When in_valid = 0 at a rising edge, out_valid SHALL go 0 after that edge and out_poly SHALL hold its previous value.
REQ-014 There SHALL be no backpressure; every in_valid cycle SHALL be accepted.
REQ-015 Back-to-back valid inputs SHALL produce back-to-back results, one per cycle, in order, with out_valid held high continuously.
REQ-016 in_poly SHALL be ignored (don't-care) when in_valid = 0.

Reset
REQ-017 When rst_n is asserted low, out_valid SHALL go 0 and out_poly SHALL go 35'd0 immediately, independent of clk.
REQ-018 The reset value of out_poly SHALL be 0, not r(0) = 1.
REQ-019 While rst_n = 0, the outputs SHALL hold their reset values and in_valid SHALL be ignored.
REQ-020 After rst_n deasserts, the first valid input sampled SHALL produce its result with the normal 1-cycle latency.
REQ-021 A reset asserted mid-stream SHALL discard the pending result; no stale result SHALL appear after reset release.

Verification
REQ-022 in_poly = 478163327 (0x1C80317F), in_valid = 1 -> next cycle out_poly = 7860332174 (0x1D483268E), out_valid = 1.
REQ-023 in_poly = 0 -> out_poly = 1; in_poly = 1 -> out_poly = 16 (0x10), confirming the constant cancels bit 0.
REQ-024 in_poly = 0x7FFFFFFF -> out_poly = 0x78000000E; in_poly = 0x40000000 -> out_poly = 0x440000001, checking the top-bit span.
REQ-025 Stream of 4 consecutive valid operands followed by in_valid = 0 -> 4 in-order results with out_valid high for 4 cycles, then out_valid = 0 and out_poly held.
REQ-026 rst_n pulsed low between clock edges while out_valid = 1 -> out_poly = 0 and out_valid = 0 immediately, remaining so until the first valid input after release.
REQ-027 Randomized check: 10000 random operands, each compared against the (p << 4) XOR p XOR 1 reference model.
